afu_ctrl_regs: RTL and testbench

- AXI4-Lite control-register slave inside the XRT AFU wrapper.
- Sits directly downstream of the AFU top-level s_axi_ctrl port.
- Decodes host accesses into kernel start/done handshakes, device-capability readback, DCR writes toward the Vortex core, and the host interrupt.
- Has independent write and read FSMs and single-outstanding transactions.

---
 rtl/afu_ctrl_regs_pkg.sv | 56 +++++
 rtl/afu_ctrl_regs_if.sv | 42 ++++
 rtl/afu_ctrl_regs.sv | 268 ++++++++++++++++++++++++++
 tb/tb_afu_ctrl_regs.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afu_ctrl_regs_pkg.sv
// -----------------------------------------------------------------------------
// afu_ctrl_pkg
// Shared definitions for the AFU control-register slave:
//   - byte offsets of every register in the s_axi_ctrl address map
//   - bit positions inside AP_CTRL and ISR/IER
//   - write / read FSM state encodings
//   - apply_wstrb(): byte-lane merge used for byte-strobed RW registers
// -----------------------------------------------------------------------------
package afu_ctrl_pkg;

   // Register byte offsets
   localparam logic [7:0] ADDR_AP_CTRL  = 8'h00;
   localparam logic [7:0] ADDR_GIE      = 8'h04;
   localparam logic [7:0] ADDR_IER      = 8'h08;
   localparam logic [7:0] ADDR_ISR      = 8'h0C;
   localparam logic [7:0] ADDR_DEV_LO   = 8'h10;
   localparam logic [7:0] ADDR_DEV_HI   = 8'h14;
   localparam logic [7:0] ADDR_ISA_LO   = 8'h18;
   localparam logic [7:0] ADDR_ISA_HI   = 8'h1C;
   localparam logic [7:0] ADDR_DCR_ADDR = 8'h20;
   localparam logic [7:0] ADDR_DCR_DATA = 8'h24;

   // AP_CTRL bit positions
   localparam int AP_START_BIT        = 0;
   localparam int AP_DONE_BIT         = 1;
   localparam int AP_IDLE_BIT         = 2;
   localparam int AP_READY_BIT        = 3;
   localparam int AP_AUTO_RESTART_BIT = 7;

   // ISR / IER bit positions
   localparam int IRQ_DONE_BIT  = 0;
   localparam int IRQ_READY_BIT = 1;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_DATA = 2'd1,
      WR_RESP = 2'd2
   } wr_state_e;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_DATA = 1'b1
   } rd_state_e;

   // Replace each byte of old_val whose strobe bit is set with the new byte
   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/afu_ctrl_regs_if.sv
// -----------------------------------------------------------------------------
// afu_ctrl_regs_if
// AXI4-Lite control bus (s_axi_ctrl) between the host-side master and the
// control-register slave.
//   write address : awvalid/awready/awaddr
//   write data    : wvalid/wready/wdata/wstrb
//   write resp    : bvalid/bready/bresp
//   read address  : arvalid/arready/araddr
//   read data     : rvalid/rready/rdata/rresp
// Modports: master (host side), slave (register block).
// -----------------------------------------------------------------------------
interface afu_ctrl_regs_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  awvalid;
   logic                  awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  wvalid;
   logic                  wready;
   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  rvalid;
   logic                  rready;
   logic [31:0]           rdata;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/afu_ctrl_regs.sv
// -----------------------------------------------------------------------------
// afu_ctrl_regs
// AXI4-Lite control-register slave of the AFU wrapper. Turns host accesses
// into the kernel start/done handshake, capability readback, DCR writes
// toward the core and the host interrupt.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   s_axi_ctrl            : AXI4-Lite slave (independent write/read FSMs,
//                           one outstanding transaction per direction)
//   ap_start              : kernel run request (level)
//   ap_ready / ap_done    : kernel pulses (start accepted / finished)
//   ap_idle               : kernel idle level
//   dev_caps / isa_caps   : 64-bit capability words, read back as lo/hi
//   dcr_wr_valid/addr/data: one-cycle DCR write strobe to the core
//   interrupt             : level interrupt, GIE & |ISR (registered)
// -----------------------------------------------------------------------------
module afu_ctrl_regs
   import afu_ctrl_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 8,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int DCR_ADDR_WIDTH = 12
) (
   input  logic                      clk,
   input  logic                      reset,
   afu_ctrl_regs_if.slave            s_axi_ctrl,
   output logic                      ap_start,
   input  logic                      ap_ready,
   input  logic                      ap_done,
   input  logic                      ap_idle,
   input  logic [63:0]               dev_caps,
   input  logic [63:0]               isa_caps,
   output logic                      dcr_wr_valid,
   output logic [DCR_ADDR_WIDTH-1:0] dcr_wr_addr,
   output logic [31:0]               dcr_wr_data,
   output logic                      interrupt
);

   // FSM state and registered channel flags
   wr_state_e wr_state_r, wr_next_s;
   rd_state_e rd_state_r, rd_next_s;
   logic awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
   logic aw_ready_nxt_s, w_ready_nxt_s, b_valid_nxt_s, ar_ready_nxt_s, r_valid_nxt_s;
   logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

   // Register file
   logic [AXI_ADDR_WIDTH-1:2] wr_word_r;
   logic                      ap_start_r, auto_restart_r, done_r, idle_r, ready_r;
   logic                      gie_r, interrupt_r;
   logic [1:0]                ier_r, isr_r;
   logic [DCR_ADDR_WIDTH-1:0] dcr_addr_r;
   logic                      dcr_wr_valid_r;
   logic [31:0]               dcr_wr_data_r;
   logic [AXI_DATA_WIDTH-1:0] rdata_r;

   // Decode / next-value signals
   logic [AXI_ADDR_WIDTH-1:0] wr_off_s, rd_off_s;
   logic wr_ctrl_s, wr_gie_s, wr_ier_s, wr_isr_s, wr_dcra_s, wr_dcrd_s;
   logic [1:0]                isr_tgl_s, isr_set_s, isr_nxt_s;
   logic [31:0]               dcr_merge_s;
   logic [AXI_DATA_WIDTH-1:0] rd_mux_s;
   logic                      unused_s;

   assign aw_hs_s = s_axi_ctrl.awvalid & awready_r;
   assign w_hs_s  = s_axi_ctrl.wvalid  & wready_r;
   assign b_hs_s  = bvalid_r & s_axi_ctrl.bready;
   assign ar_hs_s = s_axi_ctrl.arvalid & arready_r;
   assign r_hs_s  = rvalid_r & s_axi_ctrl.rready;

   // Byte offsets with the ignored lane bits forced to zero
   assign wr_off_s = {wr_word_r, 2'b00};
   assign rd_off_s = {s_axi_ctrl.araddr[AXI_ADDR_WIDTH-1:2], 2'b00};

   assign wr_ctrl_s = w_hs_s && (wr_off_s == AXI_ADDR_WIDTH'(ADDR_AP_CTRL));
   assign wr_gie_s  = w_hs_s && (wr_off_s == AXI_ADDR_WIDTH'(ADDR_GIE));
   assign wr_ier_s  = w_hs_s && (wr_off_s == AXI_ADDR_WIDTH'(ADDR_IER));
   assign wr_isr_s  = w_hs_s && (wr_off_s == AXI_ADDR_WIDTH'(ADDR_ISR));
   assign wr_dcra_s = w_hs_s && (wr_off_s == AXI_ADDR_WIDTH'(ADDR_DCR_ADDR));
   assign wr_dcrd_s = w_hs_s && (wr_off_s == AXI_ADDR_WIDTH'(ADDR_DCR_DATA));

   // ---------------------------------------------------------------- write FSM
   // Write FSM state register; channel flags are registered from the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_state_r <= WR_IDLE;
         awready_r  <= 1'b0;
         wready_r   <= 1'b0;
         bvalid_r   <= 1'b0;
         wr_word_r  <= '0;
      end else begin
         wr_state_r <= wr_next_s;
         awready_r  <= aw_ready_nxt_s;
         wready_r   <= w_ready_nxt_s;
         bvalid_r   <= b_valid_nxt_s;
         if (aw_hs_s) begin
            wr_word_r <= s_axi_ctrl.awaddr[AXI_ADDR_WIDTH-1:2];
         end
      end
   end

   // Write FSM next-state logic
   always_comb begin
      wr_next_s = wr_state_r;
      case (wr_state_r)
         WR_IDLE: if (aw_hs_s) wr_next_s = WR_DATA; else wr_next_s = WR_IDLE;
         WR_DATA: if (w_hs_s)  wr_next_s = WR_RESP; else wr_next_s = WR_DATA;
         WR_RESP: if (b_hs_s)  wr_next_s = WR_IDLE; else wr_next_s = WR_RESP;
         default: wr_next_s = WR_IDLE;
      endcase
   end

   // Write FSM outputs, decoded from the next state so they leave a flop
   always_comb begin
      aw_ready_nxt_s = (wr_next_s == WR_IDLE);
      w_ready_nxt_s  = (wr_next_s == WR_DATA);
      b_valid_nxt_s  = (wr_next_s == WR_RESP);
   end

   // ----------------------------------------------------------------- read FSM
   // Read FSM state register and read-data capture
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_state_r <= RD_IDLE;
         arready_r  <= 1'b0;
         rvalid_r   <= 1'b0;
         rdata_r    <= '0;
      end else begin
         rd_state_r <= rd_next_s;
         arready_r  <= ar_ready_nxt_s;
         rvalid_r   <= r_valid_nxt_s;
         // Captured from the current register values, so a same-cycle write
         // is not visible to this read.
         if (ar_hs_s) begin
            rdata_r <= rd_mux_s;
         end
      end
   end

   // Read FSM next-state logic
   always_comb begin
      rd_next_s = rd_state_r;
      case (rd_state_r)
         RD_IDLE: if (ar_hs_s) rd_next_s = RD_DATA; else rd_next_s = RD_IDLE;
         RD_DATA: if (r_hs_s)  rd_next_s = RD_IDLE; else rd_next_s = RD_DATA;
         default: rd_next_s = RD_IDLE;
      endcase
   end

   // Read FSM outputs, decoded from the next state
   always_comb begin
      ar_ready_nxt_s = (rd_next_s == RD_IDLE);
      r_valid_nxt_s  = (rd_next_s == RD_DATA);
   end

   // Read decode mux; unmapped and write-only offsets read as zero
   always_comb begin
      rd_mux_s = '0;
      case (rd_off_s)
         AXI_ADDR_WIDTH'(ADDR_AP_CTRL): begin
            rd_mux_s[AP_START_BIT]        = ap_start_r;
            rd_mux_s[AP_DONE_BIT]         = done_r;
            rd_mux_s[AP_IDLE_BIT]         = idle_r;
            rd_mux_s[AP_READY_BIT]        = ready_r;
            rd_mux_s[AP_AUTO_RESTART_BIT] = auto_restart_r;
         end
         AXI_ADDR_WIDTH'(ADDR_GIE):      rd_mux_s = {31'd0, gie_r};
         AXI_ADDR_WIDTH'(ADDR_IER):      rd_mux_s = {30'd0, ier_r};
         AXI_ADDR_WIDTH'(ADDR_ISR):      rd_mux_s = {30'd0, isr_r};
         AXI_ADDR_WIDTH'(ADDR_DEV_LO):   rd_mux_s = dev_caps[31:0];
         AXI_ADDR_WIDTH'(ADDR_DEV_HI):   rd_mux_s = dev_caps[63:32];
         AXI_ADDR_WIDTH'(ADDR_ISA_LO):   rd_mux_s = isa_caps[31:0];
         AXI_ADDR_WIDTH'(ADDR_ISA_HI):   rd_mux_s = isa_caps[63:32];
         AXI_ADDR_WIDTH'(ADDR_DCR_ADDR): rd_mux_s = {{(AXI_DATA_WIDTH-DCR_ADDR_WIDTH){1'b0}}, dcr_addr_r};
         default:                        rd_mux_s = '0;
      endcase
   end

   // ------------------------------------------------------------ register file
   // ISR next value: host toggle first, then hardware set so the set wins
   always_comb begin
      if (wr_isr_s && s_axi_ctrl.wstrb[0]) begin
         isr_tgl_s = s_axi_ctrl.wdata[1:0];
      end else begin
         isr_tgl_s = 2'b00;
      end
      isr_set_s[IRQ_DONE_BIT]  = ap_done  & ier_r[IRQ_DONE_BIT];
      isr_set_s[IRQ_READY_BIT] = ap_ready & ier_r[IRQ_READY_BIT];
      isr_nxt_s = (isr_r ^ isr_tgl_s) | isr_set_s;
   end

   // Byte-strobed merge for the DCR address register
   always_comb begin
      dcr_merge_s = apply_wstrb({{(32-DCR_ADDR_WIDTH){1'b0}}, dcr_addr_r},
                                s_axi_ctrl.wdata, s_axi_ctrl.wstrb);
   end

   // Control/status registers, interrupt and DCR strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         ap_start_r     <= 1'b0;
         auto_restart_r <= 1'b0;
         done_r         <= 1'b0;
         idle_r         <= 1'b0;
         ready_r        <= 1'b0;
         gie_r          <= 1'b0;
         ier_r          <= 2'b00;
         isr_r          <= 2'b00;
         interrupt_r    <= 1'b0;
         dcr_addr_r     <= '0;
         dcr_wr_valid_r <= 1'b0;
         dcr_wr_data_r  <= 32'd0;
      end else begin
         if (wr_ctrl_s && s_axi_ctrl.wstrb[0]) begin
            auto_restart_r <= s_axi_ctrl.wdata[AP_AUTO_RESTART_BIT];
         end
         // Host can only set start; the kernel clears it via ap_ready
         if (wr_ctrl_s && s_axi_ctrl.wstrb[0] && s_axi_ctrl.wdata[AP_START_BIT]) begin
            ap_start_r <= 1'b1;
         end else if (ap_ready && !auto_restart_r) begin
            ap_start_r <= 1'b0;
         end
         // A new done pulse beats the clear-on-read
         if (ap_done) begin
            done_r <= 1'b1;
         end else if (ar_hs_s && (rd_off_s == AXI_ADDR_WIDTH'(ADDR_AP_CTRL))) begin
            done_r <= 1'b0;
         end
         idle_r  <= ap_idle;
         ready_r <= ap_ready;
         if (wr_gie_s && s_axi_ctrl.wstrb[0]) begin
            gie_r <= s_axi_ctrl.wdata[0];
         end
         if (wr_ier_s && s_axi_ctrl.wstrb[0]) begin
            ier_r <= s_axi_ctrl.wdata[1:0];
         end
         isr_r       <= isr_nxt_s;
         interrupt_r <= gie_r & (|isr_r);
         if (wr_dcra_s) begin
            dcr_addr_r <= dcr_merge_s[DCR_ADDR_WIDTH-1:0];
         end
         // Only full-word writes fire the DCR strobe
         dcr_wr_valid_r <= wr_dcrd_s && (s_axi_ctrl.wstrb == 4'hF);
         if (wr_dcrd_s) begin
            dcr_wr_data_r <= s_axi_ctrl.wdata;
         end
      end
   end

   assign s_axi_ctrl.awready = awready_r;
   assign s_axi_ctrl.wready  = wready_r;
   assign s_axi_ctrl.bvalid  = bvalid_r;
   assign s_axi_ctrl.bresp   = 2'b00;
   assign s_axi_ctrl.arready = arready_r;
   assign s_axi_ctrl.rvalid  = rvalid_r;
   assign s_axi_ctrl.rdata   = rdata_r;
   assign s_axi_ctrl.rresp   = 2'b00;

   assign ap_start     = ap_start_r;
   assign interrupt    = interrupt_r;
   assign dcr_wr_valid = dcr_wr_valid_r;
   assign dcr_wr_addr  = dcr_addr_r;
   assign dcr_wr_data  = dcr_wr_data_r;

   // Lane-select address bits and the DCR merge bits above the address width
   assign unused_s = ^{s_axi_ctrl.araddr[1:0], s_axi_ctrl.awaddr[1:0],
                       dcr_merge_s[31:DCR_ADDR_WIDTH]};

endmodule

// File: tb/tb_afu_ctrl_regs.sv
// -----------------------------------------------------------------------------
// tb_afu_ctrl_regs
// Directed stimulus with hand-computed expectations. Read data, write
// responses and DCR strobes are checked by a monitor against expectation
// queues filled when the stimulus is issued; level outputs are probed
// mid-cycle by the stimulus process.
// -----------------------------------------------------------------------------
module tb_afu_ctrl_regs;

   logic        clk;
   logic        reset;
   logic        ap_start, ap_ready, ap_done, ap_idle;
   logic [63:0] dev_caps, isa_caps;
   logic        dcr_wr_valid;
   logic [11:0] dcr_wr_addr;
   logic [31:0] dcr_wr_data;
   logic        interrupt;

   int checks = 0;
   int errors = 0;
   int dcr_cnt = 0;

   logic [31:0] rd_exp_q[$];
   logic [1:0]  wr_exp_q[$];
   logic [43:0] dcr_exp_q[$];

   afu_ctrl_regs_if #(.ADDR_WIDTH(8)) axi ();

   afu_ctrl_regs #(
      .AXI_ADDR_WIDTH(8),
      .AXI_DATA_WIDTH(32),
      .DCR_ADDR_WIDTH(12)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .s_axi_ctrl   (axi),
      .ap_start     (ap_start),
      .ap_ready     (ap_ready),
      .ap_done      (ap_done),
      .ap_idle      (ap_idle),
      .dev_caps     (dev_caps),
      .isa_caps     (isa_caps),
      .dcr_wr_valid (dcr_wr_valid),
      .dcr_wr_addr  (dcr_wr_addr),
      .dcr_wr_data  (dcr_wr_data),
      .interrupt    (interrupt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic hs_cond(input int which);
      case (which)
         0:       return axi.awready;
         1:       return axi.wready;
         2:       return axi.arready;
         3:       return axi.bvalid & axi.bready;
         default: return axi.rvalid & axi.rready;
      endcase
   endfunction

   // Wait (bounded) until the channel is ready at a negedge, then cross the edge
   task automatic wait_hs(input string name, input int which);
      logic got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         if (hs_cond(which)) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no handshake, expected one within 50 cycles", name);
      end else begin
         tick();
      end
   endtask

   task automatic axi_aw_w(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
      wr_exp_q.push_back(2'b00);
      axi.awvalid = 1'b1;
      axi.awaddr  = addr;
      wait_hs("aw", 0);
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b1;
      axi.wdata   = data;
      axi.wstrb   = strb;
      wait_hs("w", 1);
      axi.wvalid  = 1'b0;
   endtask

   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
      axi_aw_w(addr, data, strb);
      wait_hs("b", 3);
   endtask

   task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp,
                           input int hold, input logic with_done);
      rd_exp_q.push_back(exp);
      if (hold > 0) axi.rready = 1'b0;
      axi.arvalid = 1'b1;
      axi.araddr  = addr;
      if (with_done) ap_done = 1'b1;
      wait_hs("ar", 2);
      axi.arvalid = 1'b0;
      ap_done     = 1'b0;
      #3;
      chk("rvalid_latency", axi.rvalid, 1);
      if (hold > 0) begin
         repeat (hold) tick();
         axi.rready = 1'b1;
      end
      wait_hs("r", 4);
   endtask

   task automatic pulse_done();
      ap_done = 1'b1;
      tick();
      ap_done = 1'b0;
   endtask

   // Monitor: compares every DUT response against the expectation queues
   always @(negedge clk) begin
      if (!reset) begin
         if (axi.rvalid) begin
            if (rd_exp_q.size() == 0) begin
               chk("rd_unexpected", 1, 0);
            end else if (axi.rready) begin
               chk("rresp", axi.rresp, 0);
               chk("rdata", axi.rdata, rd_exp_q.pop_front());
            end else begin
               chk("rdata_stable", axi.rdata, rd_exp_q[0]);
            end
         end
         if (axi.bvalid && axi.bready) begin
            if (wr_exp_q.size() == 0) chk("b_unexpected", 1, 0);
            else chk("bresp", axi.bresp, wr_exp_q.pop_front());
         end
         if (dcr_wr_valid) begin
            dcr_cnt++;
            if (dcr_exp_q.size() == 0) chk("dcr_unexpected", 1, 0);
            else chk("dcr_addr_data", {dcr_wr_addr, dcr_wr_data}, dcr_exp_q.pop_front());
         end
      end
   end

   // Watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      reset = 1'b1;
      ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1;
      dev_caps = 64'h0123456789ABCDEF;
      isa_caps = 64'hFEDCBA9876543210;
      axi.awvalid = 1'b0; axi.awaddr = 8'h00;
      axi.wvalid = 1'b0; axi.wdata = 32'd0; axi.wstrb = 4'h0;
      axi.bready = 1'b1;
      axi.arvalid = 1'b0; axi.araddr = 8'h00;
      axi.rready = 1'b1;

      // Reset state
      repeat (3) tick();
      #3;
      chk("rst_awready", axi.awready, 0);
      chk("rst_arready", axi.arready, 0);
      chk("rst_wready", axi.wready, 0);
      chk("rst_bvalid", axi.bvalid, 0);
      chk("rst_rvalid", axi.rvalid, 0);
      chk("rst_ap_start", ap_start, 0);
      chk("rst_interrupt", interrupt, 0);
      chk("rst_dcr_valid", dcr_wr_valid, 0);
      tick();
      reset = 1'b0;
      tick();
      #3;
      chk("awready_after_rst", axi.awready, 1);
      chk("arready_after_rst", axi.arready, 1);

      // ap_start set by host, cleared by ap_ready
      axi_aw_w(8'h00, 32'h1, 4'hF);
      #3;
      chk("start_after_w", ap_start, 1);
      wait_hs("b", 3);
      repeat (5) tick();
      ap_ready = 1'b1;
      #3;
      chk("start_before_ready", ap_start, 1);
      tick();
      ap_ready = 1'b0;
      #3;
      chk("start_cleared", ap_start, 0);
      // auto_restart keeps start; a write of 0 does not clear it
      axi_write(8'h00, 32'h81, 4'hF);
      ap_ready = 1'b1;
      tick();
      ap_ready = 1'b0;
      #3;
      chk("start_auto_restart", ap_start, 1);
      axi_write(8'h00, 32'h80, 4'hF);
      #3;
      chk("start_write0", ap_start, 1);

      // done bit: clear-on-read, same-cycle ap_done wins
      axi_read(8'h00, 32'h85, 0, 1'b0);
      pulse_done();
      axi_read(8'h00, 32'h87, 0, 1'b0);
      axi_read(8'h00, 32'h85, 0, 1'b0);
      axi_read(8'h00, 32'h85, 0, 1'b1);
      axi_read(8'h00, 32'h87, 0, 1'b0);
      axi_read(8'h00, 32'h85, 0, 1'b0);

      // Interrupt path
      axi_write(8'h04, 32'h1, 4'hF);
      axi_write(8'h08, 32'h1, 4'hF);
      pulse_done();
      #3;
      chk("irq_lag1", interrupt, 0);
      tick();
      #3;
      chk("irq_lag2", interrupt, 1);
      axi_read(8'h0C, 32'h1, 0, 1'b0);
      axi_write(8'h0C, 32'h1, 4'hF);
      #3;
      chk("irq_cleared", interrupt, 0);
      axi_write(8'h04, 32'h0, 4'hF);
      pulse_done();
      repeat (3) tick();
      #3;
      chk("irq_gie_off", interrupt, 0);
      axi_read(8'h0C, 32'h1, 0, 1'b0);
      axi_write(8'h0C, 32'h1, 4'hF);
      axi_write(8'h0C, 32'h2, 4'hF);
      axi_read(8'h0C, 32'h2, 0, 1'b0);
      axi_write(8'h0C, 32'h2, 4'hF);
      axi_read(8'h0C, 32'h0, 0, 1'b0);
      axi_read(8'h04, 32'h0, 0, 1'b0);
      axi_read(8'h08, 32'h1, 0, 1'b0);
      axi_read(8'h00, 32'h87, 0, 1'b0);
      axi_read(8'h00, 32'h85, 0, 1'b0);

      // DCR writes
      axi_write(8'h20, 32'h005, 4'hF);
      axi_read(8'h20, 32'h005, 0, 1'b0);
      c0 = dcr_cnt;
      dcr_exp_q.push_back({12'h005, 32'hDEADBEEF});
      axi_aw_w(8'h24, 32'hDEADBEEF, 4'hF);
      #3;
      chk("dcr_pulse_on", dcr_wr_valid, 1);
      wait_hs("b", 3);
      #3;
      chk("dcr_pulse_off", dcr_wr_valid, 0);
      chk("dcr_count_full", dcr_cnt, c0 + 1);
      axi_aw_w(8'h24, 32'hCAFEF00D, 4'h3);
      #3;
      chk("dcr_partial_none", dcr_wr_valid, 0);
      wait_hs("b", 3);
      tick();
      chk("dcr_count_partial", dcr_cnt, c0 + 1);
      axi_write(8'h20, 32'h00000ABC, 4'h1);
      axi_read(8'h20, 32'h0BC, 0, 1'b0);
      dcr_exp_q.push_back({12'h0BC, 32'h12345678});
      axi_write(8'h24, 32'h12345678, 4'hF);
      tick();

      // Capability readback with read-data backpressure
      axi_read(8'h10, 32'h89ABCDEF, 4, 1'b0);
      axi_read(8'h14, 32'h01234567, 4, 1'b0);
      axi_read(8'h18, 32'h76543210, 0, 1'b0);
      axi_read(8'h1C, 32'hFEDCBA98, 0, 1'b0);
      axi_read(8'h3C, 32'h0, 0, 1'b0);
      axi_read(8'h24, 32'h0, 0, 1'b0);

      // Load state, then reset in the middle of a write response
      axi_write(8'h04, 32'h1, 4'hF);
      axi_write(8'h08, 32'h3, 4'hF);
      axi_write(8'h0C, 32'h1, 4'hF);
      ap_ready = 1'b1;
      tick();
      ap_ready = 1'b0;
      axi_read(8'h0C, 32'h3, 0, 1'b0);
      #3;
      chk("irq_before_rst", interrupt, 1);
      axi_write(8'h20, 32'h7FF, 4'hF);
      ap_idle = 1'b0;
      axi.bready = 1'b0;
      axi_aw_w(8'h04, 32'h1, 4'hF);
      #3;
      chk("bvalid_held", axi.bvalid, 1);
      tick();
      reset = 1'b1;
      repeat (2) tick();
      #3;
      chk("rst_mid_bvalid", axi.bvalid, 0);
      chk("rst_mid_awready", axi.awready, 0);
      chk("rst_mid_ap_start", ap_start, 0);
      chk("rst_mid_interrupt", interrupt, 0);
      wr_exp_q.delete();
      axi.bready = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      #3;
      chk("awready_after_rst2", axi.awready, 1);
      chk("arready_after_rst2", axi.arready, 1);
      axi_read(8'h00, 32'h0, 0, 1'b0);
      axi_read(8'h04, 32'h0, 0, 1'b0);
      axi_read(8'h08, 32'h0, 0, 1'b0);
      axi_read(8'h0C, 32'h0, 0, 1'b0);
      axi_read(8'h20, 32'h0, 0, 1'b0);
      repeat (3) tick();

      chk("rd_queue_empty", rd_exp_q.size(), 0);
      chk("wr_queue_empty", wr_exp_q.size(), 0);
      chk("dcr_queue_empty", dcr_exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
